// File: rtl/acct_pkg.sv
// Shared constants for the account min-cost window scheduler: FSM encoding,
// frame length limits and window depth.
package acct_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CLR  = 3'd1;
  localparam logic [2:0] ST_FILL = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  localparam int unsigned MIN_LEN = 5;
  localparam int unsigned MAX_LEN = 4000;
  localparam int unsigned WINDOW  = 5;

  // Credit counter width; holds CREDITS up to 15.
  localparam int unsigned CRD_W = 4;

  function automatic logic len_legal(input int unsigned len);
    return (len >= MIN_LEN) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/acct_credit_cnt.sv
// Downstream output-slot credit counter: reloads on init, one slot per consume,
// one per return; a return with every slot already free is flagged, not counted.
module acct_credit_cnt
  import acct_pkg::*;
#(
  parameter int CREDITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_i,
  input  logic consume_i,
  input  logic ret_i,
  output logic avail_o,
  output logic ovf_o
);

  localparam logic [CRD_W-1:0] FULL = CRD_W'(CREDITS);

  logic [CRD_W-1:0] cnt_q, cnt_d;
  logic             full;

  assign full    = (cnt_q == FULL);
  assign avail_o = (cnt_q != '0);

  // A consume and return in the same cycle cancel, even when full.
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (init_i) begin
      cnt_d = FULL;
    end else begin
      case ({consume_i, ret_i})
        2'b10: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        2'b01: begin
          if (full) ovf_o = 1'b1;
          else      cnt_d = cnt_q + 1'b1;
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= FULL;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/acct_window_sched.sv
// Frame controller for the 5-deep min(A*T) window datapath: clears it, fills
// WINDOW-1 samples, then emits one result per accepted sample under credit flow.
module acct_window_sched
  import acct_pkg::*;
#(
  parameter int CREDITS = 8,
  parameter int LSIZE   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LSIZE-1:0] cfg_len,
  input  logic             in_valid,
  output logic             ready,
  input  logic             credit_ret,
  output logic             dp_clear,
  output logic             dp_shift,
  output logic             dp_emit,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LSIZE-1:0] out_cnt
);

  // in_cnt value at which the accept completes the window pre-fill.
  localparam logic [LSIZE-1:0] FILL_LAST = LSIZE'(WINDOW - 2);

  logic [2:0]       state_q, state_d;
  logic [LSIZE-1:0] len_q, len_d;
  logic [LSIZE-1:0] in_cnt_q, in_cnt_d;
  logic [LSIZE-1:0] out_cnt_q, out_cnt_d;
  logic             err_q, busy_q, done_q, clear_q;

  logic             accept, more, cfg_ok, start_ok, start_bad;
  logic             crd_avail, crd_ovf;

  assign more      = (in_cnt_q < len_q);
  assign cfg_ok    = len_legal(32'(cfg_len));
  assign start_ok  = (state_q == ST_IDLE) && start && cfg_ok;
  assign start_bad = (state_q == ST_IDLE) && start && !cfg_ok;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_FILL: ready = more;
      ST_RUN:  ready = more && crd_avail;
      default: ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && ready;
  assign dp_shift = accept;
  assign dp_emit  = accept && (state_q == ST_RUN);

  acct_credit_cnt #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_i    (start_ok),
    .consume_i (dp_emit),
    .ret_i     (credit_ret),
    .avail_o   (crd_avail),
    .ovf_o     (crd_ovf)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (accept)  in_cnt_d  = in_cnt_q + 1'b1;
    if (dp_emit) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        // Counters clear on entry so CLR already shows a fresh frame.
        if (start_ok) begin
          state_d   = ST_CLR;
          len_d     = cfg_len;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      ST_CLR:  state_d = ST_FILL;
      ST_FILL: if (accept && (in_cnt_q == FILL_LAST)) state_d = ST_RUN;
      ST_RUN:  if (accept && (in_cnt_d == len_q))     state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_q | start_bad | crd_ovf;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_FIN);
      clear_q   <= (state_d == ST_CLR);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dp_clear = clear_q;
  assign err      = err_q;
  assign out_cnt  = out_cnt_q;

endmodule

// File: tb/tb_acct_window_sched.sv
// Directed bench for acct_window_sched: frame sequencing, credit flow,
// error cases and mid-frame reset, with hand-computed expectations.
module tb_acct_window_sched;
  localparam int LSIZE = 12;

  logic             clk = 1'b0;
  logic             rst_n, start, in_valid, credit_ret;
  logic [LSIZE-1:0] cfg_len;
  logic             ready, dp_clear, dp_shift, dp_emit, busy, done, err;
  logic [LSIZE-1:0] out_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_shift = 0, n_emit = 0, n_done = 0, n_clear = 0;
  int drops;

  acct_window_sched #(.CREDITS(8), .LSIZE(LSIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .ready(ready), .credit_ret(credit_ret),
    .dp_clear(dp_clear), .dp_shift(dp_shift), .dp_emit(dp_emit),
    .busy(busy), .done(done), .err(err), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dp_shift) n_shift++;
    if (dp_emit)  n_emit++;
    if (done)     n_done++;
    if (dp_clear) n_clear++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic samp;
    @(negedge clk); #1;
  endtask

  task automatic clr_counts;
    n_shift = 0; n_emit = 0; n_done = 0; n_clear = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; credit_ret = 1'b0; cfg_len = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  // Streams n cycles with in_valid high; credits returned once RUN begins.
  task automatic stream(input int n);
    drops = 0;
    for (int k = 0; k < n; k++) begin
      credit_ret = (k >= 4);
      @(negedge clk);
      if (!ready) drops++;
      @(posedge clk); #1;
    end
    credit_ret = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset;
    samp;
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", dp_clear, 0);
    chk("rst_outcnt", out_cnt, 0);

    // shortest frame, in_valid held
    tick; clr_counts;
    start = 1'b1; cfg_len = 12'd5; in_valid = 1'b1;
    tick; start = 1'b0;
    samp;
    chk("l5_clr", dp_clear, 1);
    chk("l5_clr_busy", busy, 1);
    chk("l5_clr_ready", ready, 0);
    repeat (4) tick;
    samp;
    chk("l5_fill_shift", n_shift, 4);
    chk("l5_fill_emit", n_emit, 0);
    chk("l5_clr_once", n_clear, 1);
    tick; samp;
    chk("l5_run_emit", dp_emit, 1);
    chk("l5_run_shift", n_shift, 5);
    tick; samp;
    chk("l5_fin_done", done, 1);
    chk("l5_fin_ready", ready, 0);
    chk("l5_outcnt", out_cnt, 1);
    tick; samp;
    chk("l5_idle_busy", busy, 0);
    chk("l5_done_once", n_done, 1);
    chk("l5_total_shift", n_shift, 5);
    chk("l5_err", err, 0);
    in_valid = 1'b0;

    // credit starvation, ignored start, one returned credit
    tick; clr_counts;
    start = 1'b1; cfg_len = 12'd20; in_valid = 1'b1;
    tick; start = 1'b0;
    repeat (30) tick;
    samp;
    chk("c_shift", n_shift, 12);
    chk("c_emit", n_emit, 8);
    chk("c_ready0", ready, 0);
    chk("c_outcnt", out_cnt, 8);
    tick; start = 1'b1; cfg_len = 12'd5;
    tick; start = 1'b0;
    repeat (3) tick;
    samp;
    chk("c_nostart_shift", n_shift, 12);
    chk("c_nostart_clr", n_clear, 1);
    chk("c_nostart_busy", busy, 1);
    chk("c_nostart_err", err, 0);
    tick; credit_ret = 1'b1;
    tick; credit_ret = 1'b0;
    repeat (5) tick;
    samp;
    chk("c_one_shift", n_shift, 13);
    chk("c_one_outcnt", out_cnt, 9);
    chk("c_one_ready0", ready, 0);
    tick; credit_ret = 1'b1;
    repeat (12) tick;
    credit_ret = 1'b0;
    samp;
    chk("c_end_outcnt", out_cnt, 16);
    chk("c_end_done", n_done, 1);
    chk("c_end_busy", busy, 0);
    chk("c_end_err", err, 0);
    in_valid = 1'b0;

    // longest frame, credit returned with each emit
    tick; clr_counts;
    start = 1'b1; cfg_len = 12'd4000; in_valid = 1'b1;
    tick; start = 1'b0;
    tick;
    stream(4000);
    samp;
    chk("max_drops", drops, 0);
    chk("max_done", done, 1);
    chk("max_outcnt", out_cnt, 3996);
    chk("max_shift", n_shift, 4000);
    chk("max_emit", n_emit, 3996);
    tick; samp;
    chk("max_done_once", n_done, 1);
    chk("max_busy", busy, 0);
    chk("max_err", err, 0);

    // reset in the middle of RUN
    clr_counts;
    start = 1'b1; cfg_len = 12'd200; in_valid = 1'b1;
    tick; start = 1'b0;
    tick;
    stream(100);
    samp;
    chk("mid_outcnt", out_cnt, 96);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick; samp;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_shift", dp_shift, 0);
    chk("mid_rst_outcnt", out_cnt, 0);
    chk("mid_rst_err", err, 0);
    rst_n = 1'b1;
    repeat (3) tick;
    samp;
    chk("mid_stay_idle", busy, 0);
    in_valid = 1'b0;

    // illegal lengths and unmatched credit return
    start = 1'b1; cfg_len = 12'd4;
    tick; start = 1'b0;
    samp;
    chk("len4_err", err, 1);
    chk("len4_busy", busy, 0);
    tick; samp;
    chk("len4_noclr", dp_clear, 0);
    do_reset;
    start = 1'b1; cfg_len = 12'd4001;
    tick; start = 1'b0;
    tick; samp;
    chk("len4001_err", err, 1);
    chk("len4001_busy", busy, 0);
    do_reset;
    samp;
    chk("pre_ret_err", err, 0);
    credit_ret = 1'b1;
    tick; credit_ret = 1'b0;
    samp;
    chk("fullret_err", err, 1);
    chk("fullret_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acct_window_sched.md
ACCT_WINDOW_SCHED -- requirements
Module: acct_window_sched

Interface
REQ-001 SHALL have parameter CREDITS, default 8, meaning downstream output-buffer slots (range 1..15).
REQ-002 SHALL have parameter LSIZE, default 12, meaning width of the frame-length and sample counters.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame start request.
REQ-006 SHALL have port cfg_len  input  LSIZE  frame length in samples (legal 5..4000).
REQ-007 SHALL have port in_valid  input  1  upstream sample (account, A, T) present.
REQ-008 SHALL have port ready  output  1  controller accepts a sample this cycle.
REQ-009 SHALL have port credit_ret  input  1  downstream freed one output slot.
REQ-010 SHALL have port dp_clear  output  1  flush the 5-deep min-cost window datapath.
REQ-011 SHALL have port dp_shift  output  1  shift the accepted sample into the window.
REQ-012 SHALL have port dp_emit  output  1  window result (min A*T, later index wins ties) is valid to emit.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port done  output  1  one-cycle end-of-frame pulse.
REQ-015 SHALL have port err  output  1  sticky protocol-error flag.
REQ-016 SHALL have port out_cnt  output  LSIZE  results emitted in the current frame.

Function
REQ-017 SHALL implement states IDLE, CLR, FILL, RUN, FIN.
REQ-018 IDLE: start with 5<=cfg_len<=4000 SHALL latch cfg_len and go to CLR; otherwise start SHALL set err and stay in IDLE.
REQ-019 CLR SHALL last exactly one cycle: dp_clear=1, in_cnt=0, out_cnt=0, credits=CREDITS; next state FILL.
REQ-020 accept SHALL be defined as in_valid && ready; in_valid while ready=0 SHALL be ignored without error.
REQ-021 ready SHALL be 1 in FILL when in_cnt<latched length, and in RUN when in_cnt<latched length and credits>0; 0 in all other states.
REQ-022 every accept SHALL assert dp_shift in the same cycle and increment in_cnt.
REQ-023 FILL SHALL move to RUN in the cycle after the 4th accept; no dp_emit in FILL.
REQ-024 each accept in RUN SHALL assert dp_emit the same cycle, increment out_cnt, consume one credit.
REQ-025 credits: accept-in-RUN with credit_ret same cycle SHALL leave credits unchanged; credit_ret at credits=CREDITS SHALL be ignored and set err.
REQ-026 when in_cnt reaches latched length SHALL go to FIN; FIN SHALL assert done for one cycle and return to IDLE; out_cnt SHALL then equal length-4.
REQ-027 start outside IDLE SHALL be ignored (no err, no restart).
REQ-028 busy SHALL be 1 in CLR, FILL, RUN, FIN; 0 in IDLE.
REQ-029 all outputs SHALL be registered except ready, dp_shift, dp_emit, which SHALL be combinational from state, counters, in_valid.

Reset
REQ-030 rst_n=0 at any rising edge SHALL force IDLE, credits=CREDITS, in_cnt=0, out_cnt=0, err=0 and all outputs 0, including mid-frame.
REQ-031 after reset release the block SHALL remain in IDLE until a legal start.

Structure
REQ-032 state encoding, MIN_LEN=5, MAX_LEN=4000 and WINDOW=5 SHALL live in shared package acct_pkg.
REQ-033 credit counter SHALL be a sub-module acct_credit_cnt (init, consume, return, overflow flag); remainder flat.

Verification
REQ-034 reset during RUN at in_cnt=100 -> next cycle busy=0, ready=0, out_cnt=0, err=0.
REQ-035 start, cfg_len=5, in_valid held 1 -> CLR 1 cycle, 4 shifts no emit, 1 shift+emit, done 1 cycle, out_cnt=1.
REQ-036 cfg_len=4000, CREDITS=8, credit_ret every accept -> ready never drops in RUN, out_cnt=3996, done once.
REQ-037 cfg_len=20, no credit_ret -> exactly 8 emits then ready=0; one credit_ret -> exactly one more accept.
REQ-038 start with cfg_len=4 or 4001 -> err=1, busy stays 0; credit_ret with full credits -> err=1.
REQ-039 start pulse during RUN and in_valid with ready=0 -> no restart, no shift, counters unchanged.
